// File: rtl/stopwatch_pkg.sv
// Purpose : shared types and widths for the centisecond stopwatch.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } sw_state_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Purpose : bundles the three raw buttons and the display/status outputs of the stopwatch.
// Latency : n/a (wiring only).
// Backpressure: none; buttons are levels and outputs are free-running.
// Ports   : master drives btn_* and observes outputs; slave (the stopwatch) the reverse.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic               btn_start_stop;
    logic               btn_clear;
    logic               btn_lap;
    logic [COUNT_W-1:0] displayed_number;
    logic               running;
    logic               lap_active;
    logic               overflow;

    modport master (
        output btn_start_stop, btn_clear, btn_lap,
        input  displayed_number, running, lap_active, overflow
    );

    modport slave (
        input  btn_start_stop, btn_clear, btn_lap,
        output displayed_number, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_counter_button_conditioner.sv
// Purpose : 2-FF synchroniser, debounce filter and rising-edge pulse for one raw button.
// Latency : pulse appears 2 + DEBOUNCE_CYCLES edges after a stable press reaches the pins.
// Backpressure: none; one single-cycle pulse per accepted press.
// Ports   : clk, reset (sync, active-high), btn_raw (async level), btn_pulse (1-cycle).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Count consecutive cycles where the synced input disagrees with the
        // accepted level; any agreeing cycle (a bounce) restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_pulse = pulse_q;
endmodule

// File: rtl/stopwatch_counter.sv
// Purpose : button-driven centisecond stopwatch (0..MAX_COUNT) with run/pause/clear and lap freeze.
// Latency : displayed_number is registered, one cycle behind the internal count / lap register.
// Backpressure: none; button pulses act on the next edge, lower-priority pulses in a cycle are dropped.
// Ports   : clk, reset (sync, active-high), sw (slave modport: raw buttons in, number/status out).
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_COUNT       = 9999,
    parameter bit WRAP            = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_counter_if.slave  sw
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]      PRE_LAST = PW'(DIV - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_COUNT);

    logic ss_p, clr_p, lap_p;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
        .clk(clk), .reset(reset), .btn_raw(sw.btn_start_stop), .btn_pulse(ss_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .reset(reset), .btn_raw(sw.btn_clear), .btn_pulse(clr_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk(clk), .reset(reset), .btn_raw(sw.btn_lap), .btn_pulse(lap_p)
    );

    sw_state_t          state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] lap_q, lap_d;
    logic [COUNT_W-1:0] disp_q, disp_d;
    logic               lap_act_q, lap_act_d;
    logic               ovf_q, ovf_d;
    logic               tick;

    assign tick = (state_q == RUN) && (presc_q == PRE_LAST);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        lap_d     = lap_q;
        lap_act_d = lap_act_q;
        ovf_d     = ovf_q;
        disp_d    = lap_act_q ? lap_q : count_q;

        unique case (state_q)
            IDLE: begin
                // Count is already zero here; a fresh run starts a full tick period.
                if (ss_p) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (count_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                        if (WRAP) begin
                            count_d = '0;
                        end else begin
                            // Saturating stop also releases any lap freeze so the
                            // final value is visible.
                            state_d   = PAUSE;
                            lap_act_d = 1'b0;
                        end
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end
                // Start/stop wins over clear, clear (ignored here) wins over lap.
                if (ss_p) begin
                    state_d   = PAUSE;
                    lap_act_d = 1'b0;
                end else if (lap_p && !clr_p && state_d == RUN) begin
                    lap_act_d = ~lap_act_q;
                    if (!lap_act_q) begin
                        lap_d = count_q;
                    end
                end
            end
            PAUSE: begin
                // Prescaler holds so a resumed run keeps its partial tick.
                if (ss_p) begin
                    state_d = RUN;
                end else if (clr_p) begin
                    state_d = IDLE;
                    count_d = '0;
                    presc_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            lap_q     <= '0;
            disp_q    <= '0;
            lap_act_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
            lap_act_q <= lap_act_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sw.displayed_number = disp_q;
    assign sw.running          = (state_q == RUN);
    assign sw.lap_active       = lap_act_q;
    assign sw.overflow         = ovf_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose : self-checking bench for stopwatch_counter (one slow instance, two fast saturate/wrap instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_stopwatch_counter;
    localparam int DEB  = 4;
    localparam int MAXC = 9999;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mb;   // main buttons:  [0]=start_stop [1]=clear [2]=lap
    logic [2:0] fb;   // fast buttons, shared by both fast instances

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_counter_if ifm ();
    stopwatch_counter_if iff0 ();
    stopwatch_counter_if iff1 ();

    assign ifm.btn_start_stop  = mb[0];
    assign ifm.btn_clear       = mb[1];
    assign ifm.btn_lap         = mb[2];
    assign iff0.btn_start_stop = fb[0];
    assign iff0.btn_clear      = fb[1];
    assign iff0.btn_lap        = fb[2];
    assign iff1.btn_start_stop = fb[0];
    assign iff1.btn_clear      = fb[1];
    assign iff1.btn_lap        = fb[2];

    stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(DEB),
                        .MAX_COUNT(MAXC), .WRAP(1'b0)) u_main (
        .clk(clk), .reset(reset), .sw(ifm));
    stopwatch_counter #(.CLK_HZ(10), .TICK_HZ(10), .DEBOUNCE_CYCLES(DEB),
                        .MAX_COUNT(MAXC), .WRAP(1'b0)) u_fast_sat (
        .clk(clk), .reset(reset), .sw(iff0));
    stopwatch_counter #(.CLK_HZ(10), .TICK_HZ(10), .DEBOUNCE_CYCLES(DEB),
                        .MAX_COUNT(MAXC), .WRAP(1'b1)) u_fast_wrap (
        .clk(clk), .reset(reset), .sw(iff1));

    logic [15:0] d_disp [3];
    logic        d_run  [3];
    logic        d_lap  [3];
    logic        d_ovf  [3];
    assign d_disp[0] = ifm.displayed_number;  assign d_run[0] = ifm.running;
    assign d_lap[0]  = ifm.lap_active;        assign d_ovf[0] = ifm.overflow;
    assign d_disp[1] = iff0.displayed_number; assign d_run[1] = iff0.running;
    assign d_lap[1]  = iff0.lap_active;       assign d_ovf[1] = iff0.overflow;
    assign d_disp[2] = iff1.displayed_number; assign d_run[2] = iff1.running;
    assign d_lap[2]  = iff1.lap_active;       assign d_ovf[2] = iff1.overflow;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: ticks per count, wrap mode; state 0=idle 1=run 2=pause.
    int       m_div  [3] = '{10, 1, 1};
    bit       m_wrap [3] = '{1'b0, 1'b0, 1'b1};
    int       m_st   [3];
    int       m_frac [3];   // run cycles since the last count increment
    int       m_cnt  [3];
    int       m_lapv [3];
    int       m_disp [3];
    bit       m_la   [3];
    bit       m_ovf  [3];
    bit [2:0] m_pend [3];   // accepted presses waiting to act
    bit [2:0] m_s1   [3];
    bit [2:0] m_s2   [3];
    bit [2:0] m_lvl  [3];
    int       m_diff [3][3];

    task automatic model_step(input int k, input logic [2:0] raw);
        bit [2:0] p;
        bit       tk;
        bit       sat;
        int       cnt0;
        bit       la0;
        if (reset) begin
            m_st[k] = 0; m_frac[k] = 0; m_cnt[k] = 0; m_lapv[k] = 0; m_disp[k] = 0;
            m_la[k] = 0; m_ovf[k] = 0; m_pend[k] = '0; m_s1[k] = '0; m_s2[k] = '0;
            m_lvl[k] = '0;
            for (int b = 0; b < 3; b++) m_diff[k][b] = 0;
            return;
        end
        p    = m_pend[k];
        cnt0 = m_cnt[k];
        la0  = m_la[k];
        sat  = 0;
        m_disp[k] = la0 ? m_lapv[k] : cnt0;
        case (m_st[k])
            0: if (p[0]) begin m_st[k] = 1; m_frac[k] = 0; end
            1: begin
                tk = (m_frac[k] + 1 == m_div[k]);
                m_frac[k] = tk ? 0 : m_frac[k] + 1;
                if (tk) begin
                    if (cnt0 == MAXC) begin
                        m_ovf[k] = 1;
                        if (m_wrap[k]) m_cnt[k] = 0;
                        else begin m_st[k] = 2; m_la[k] = 0; sat = 1; end
                    end else begin
                        m_cnt[k] = cnt0 + 1;
                    end
                end
                if (p[0]) begin
                    m_st[k] = 2; m_la[k] = 0;
                end else if (!p[1] && p[2] && !sat) begin
                    if (!la0) m_lapv[k] = cnt0;
                    m_la[k] = !la0;
                end
            end
            default: begin
                if (p[0]) m_st[k] = 1;
                else if (p[1]) begin m_st[k] = 0; m_cnt[k] = 0; m_frac[k] = 0; m_ovf[k] = 0; end
            end
        endcase
        // A button is accepted after DEB consecutive synced samples that disagree
        // with the last accepted level; only presses produce an action.
        for (int b = 0; b < 3; b++) begin
            m_pend[k][b] = 0;
            if (m_s2[k][b] != m_lvl[k][b]) begin
                m_diff[k][b]++;
                if (m_diff[k][b] == DEB) begin
                    m_lvl[k][b]  = m_s2[k][b];
                    m_diff[k][b] = 0;
                    m_pend[k][b] = m_lvl[k][b];
                end
            end else begin
                m_diff[k][b] = 0;
            end
            m_s2[k][b] = m_s1[k][b];
            m_s1[k][b] = raw[b];
        end
    endtask

    always @(posedge clk) begin
        model_step(0, mb);
        model_step(1, fb);
        model_step(2, fb);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("disp%0d", k), 32'(d_disp[k]), 32'(m_disp[k]));
            check($sformatf("run%0d", k),  32'(d_run[k]),  32'(m_st[k] == 1));
            check($sformatf("lap%0d", k),  32'(d_lap[k]),  32'(m_la[k]));
            check($sformatf("ovf%0d", k),  32'(d_ovf[k]),  32'(m_ovf[k]));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; holds the buttons in mask for 8 cycles, returns 8 negedges later.
    task automatic press(input int inst, input logic [2:0] mask);
        if (inst == 0) mb = mb | mask; else fb = fb | mask;
        repeat (8) @(negedge clk);
        if (inst == 0) mb = mb & ~mask; else fb = fb & ~mask;
    endtask

    initial begin
        reset = 1'b1;
        mb    = '0;
        fb    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: idle after reset
        repeat (100) @(negedge clk);
        check("t1_disp", 32'(ifm.displayed_number), 0);
        check("t1_run",  32'(ifm.running), 0);
        check("t1_ovf",  32'(ifm.overflow), 0);
        check("t1_lap",  32'(ifm.lap_active), 0);

        // 2: run, pause, hold, resume
        press(0, 3'b001);
        repeat (100) @(negedge clk);
        check("t2_run10", 32'(ifm.displayed_number), 10);
        check("t2_running", 32'(ifm.running), 1);
        press(0, 3'b001);
        check("t2_paused", 32'(ifm.running), 0);
        repeat (50) @(negedge clk);
        check("t2_hold10", 32'(ifm.displayed_number), 10);
        press(0, 3'b001);
        repeat (29) @(negedge clk);
        check("t2_resume13", 32'(ifm.displayed_number), 13);

        // pause then clear back to idle
        press(0, 3'b001);
        press(0, 3'b010);
        check("t3_clr_run", 32'(ifm.running), 0);
        check("t3_clr_disp", 32'(ifm.displayed_number), 0);
        repeat (10) @(negedge clk);

        // 3: bouncing start/stop is rejected, a stable press is accepted
        for (int i = 0; i < 3; i++) begin
            mb[0] = 1'b1;
            repeat (3) @(negedge clk);
            mb[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("t3_bounce", 32'(ifm.running), 0);
        press(0, 3'b001);
        check("t3_run", 32'(ifm.running), 1);

        // 4: lap freeze at 5, release at 8
        repeat (47) @(negedge clk);
        press(0, 3'b100);
        check("t4_lap_on", 32'(ifm.lap_active), 1);
        check("t4_frozen5", 32'(ifm.displayed_number), 5);
        repeat (10) @(negedge clk);
        check("t4_still5", 32'(ifm.displayed_number), 5);
        repeat (12) @(negedge clk);
        press(0, 3'b100);
        check("t4_lap_off", 32'(ifm.lap_active), 0);
        check("t4_shows8", 32'(ifm.displayed_number), 8);

        // 6: priorities and mid-run reset
        press(0, 3'b001);
        check("t6_pause", 32'(ifm.running), 0);
        check("t6_pause9", 32'(ifm.displayed_number), 9);
        repeat (12) @(negedge clk);
        press(0, 3'b011);
        check("t6_ss_clr_run", 32'(ifm.running), 1);
        check("t6_ss_clr_kept", 32'(ifm.displayed_number), 9);
        repeat (12) @(negedge clk);
        press(0, 3'b010);
        check("t6_clr_ign_run", 32'(ifm.running), 1);
        check("t6_clr_ign_val", 32'(ifm.displayed_number), 11);
        repeat (309) @(negedge clk);
        check("t6_at42", 32'(ifm.displayed_number), 42);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_disp", 32'(ifm.displayed_number), 0);
        check("t6_rst_run",  32'(ifm.running), 0);
        check("t6_rst_lap",  32'(ifm.lap_active), 0);
        check("t6_rst_ovf",  32'(ifm.overflow), 0);

        // 5: count limit, saturating and wrapping
        repeat (5) @(negedge clk);
        press(1, 3'b001);
        repeat (10010) @(negedge clk);
        check("t5_sat_disp", 32'(iff0.displayed_number), 9999);
        check("t5_sat_ovf",  32'(iff0.overflow), 1);
        check("t5_sat_run",  32'(iff0.running), 0);
        check("t5_wrap_disp", 32'(iff1.displayed_number), 10);
        check("t5_wrap_ovf",  32'(iff1.overflow), 1);
        check("t5_wrap_run",  32'(iff1.running), 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
